// File: rtl/simmem_pkg.sv
// simmem_pkg: shared widths and types for the simulated memory.
package simmem_pkg;
  localparam int IDWidth = 4;
  localparam int DelayWidth = 6;
  localparam int WriteRespSchedNumSlots = 8;
  typedef struct packed {
    logic active;
    logic [IDWidth-1:0] id;
    logic [DelayWidth-1:0] counter;
  } wresp_sched_slot_t;
endpackage

// File: rtl/simmem_rr_arbiter.sv
// simmem_rr_arbiter: combinational round-robin pick, first request at or after ptr_i.
module simmem_rr_arbiter #(
  parameter int NumReq = 8,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);
  logic found;
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && req_i[(int'(ptr_i) + k) % NumReq]) begin
        found = 1'b1;
        idx_o = IdxW'((int'(ptr_i) + k) % NumReq);
      end
    end
    gnt_o = found ? (NumReq'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/simmem_wresp_scheduler.sv
// simmem_wresp_scheduler: per-burst write-response delay with in-ID ordering
// and round-robin release among IDs.
module simmem_wresp_scheduler #(
  parameter int NumSlots = simmem_pkg::WriteRespSchedNumSlots,
  parameter int IDWidth = simmem_pkg::IDWidth,
  parameter int DelayWidth = simmem_pkg::DelayWidth,
  localparam int IdxW = $clog2(NumSlots),
  localparam int OccW = $clog2(NumSlots + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  waddr_valid_i,
  output logic                  waddr_ready_o,
  input  logic [IDWidth-1:0]    waddr_id_i,
  input  logic [DelayWidth-1:0] delay_i,
  output logic                  release_valid_o,
  input  logic                  release_ready_i,
  output logic [IDWidth-1:0]    release_id_o,
  output logic [OccW-1:0]       occupancy_o
);
  import simmem_pkg::*;
  wresp_sched_slot_t [NumSlots-1:0] slots_q, slots_d;
  logic [NumSlots-1:0][NumSlots-1:0] older_q, older_d;
  logic [IdxW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, arb_idx, gnt, free_idx;
  logic [OccW-1:0] occ_q, occ_d;
  logic lock_q, lock_d, free_found, alloc, rel;
  logic [NumSlots-1:0] act, elig, arb_oh, sel_oh;
  simmem_rr_arbiter #(.NumReq(NumSlots)) u_arb (
    .req_i(elig), .ptr_i(rr_q), .gnt_o(arb_oh), .idx_o(arb_idx)
  );
  // A slot waits while any active same-ID slot is older than it.
  always_comb begin
    elig = '0;
    act = '0;
    free_found = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NumSlots; i++) begin
      act[i] = slots_q[i].active;
      elig[i] = slots_q[i].active && slots_q[i].counter == '0;
      for (int k = 0; k < NumSlots; k++)
        if (slots_q[k].active && slots_q[k].id == slots_q[i].id && older_q[k][i]) elig[i] = 1'b0;
      if (!slots_q[i].active && !free_found) begin
        free_found = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end
  assign waddr_ready_o = ~&act;
  assign release_valid_o = lock_q | (|elig);
  assign gnt = lock_q ? lock_idx_q : arb_idx;
  assign sel_oh = lock_q ? (NumSlots'(1) << lock_idx_q) : arb_oh;
  assign release_id_o = release_valid_o ? slots_q[gnt].id : '0;
  assign occupancy_o = occ_q;
  assign alloc = waddr_valid_i & waddr_ready_o;
  assign rel = release_valid_o & release_ready_i;
  always_comb begin
    slots_d = slots_q;
    older_d = older_q;
    for (int i = 0; i < NumSlots; i++) begin
      if (slots_q[i].active && slots_q[i].counter != '0) slots_d[i].counter = slots_q[i].counter - 1'b1;
      if (rel && sel_oh[i]) begin
        slots_d[i].active = 1'b0;
        older_d[i] = '0;
        for (int k = 0; k < NumSlots; k++) older_d[k][i] = 1'b0;
      end
    end
    if (alloc) begin
      slots_d[free_idx] = '{active: 1'b1, id: waddr_id_i, counter: delay_i};
      older_d[free_idx] = '0;
      for (int k = 0; k < NumSlots; k++) older_d[k][free_idx] = act[k] && !(rel && sel_oh[k]);
    end
    rr_d = rel ? (gnt == IdxW'(NumSlots - 1) ? '0 : gnt + 1'b1) : rr_q;
    lock_d = release_valid_o & ~release_ready_i;
    lock_idx_d = gnt;
    occ_d = occ_q + OccW'(alloc) - OccW'(rel);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slots_q <= '0;
      older_q <= '0;
      rr_q <= '0;
      lock_q <= 1'b0;
      lock_idx_q <= '0;
      occ_q <= '0;
    end else begin
      slots_q <= slots_d;
      older_q <= older_d;
      rr_q <= rr_d;
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: tb/tb_simmem_wresp_scheduler.sv
// tb_simmem_wresp_scheduler: directed and random stimulus against a
// sequence-number based reference model of the scheduler.
module tb_simmem_wresp_scheduler;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic waddr_valid_i = 1'b0, release_ready_i = 1'b0;
  logic [3:0] waddr_id_i = '0;
  logic [5:0] delay_i = '0;
  logic waddr_ready_o, release_valid_o;
  logic [3:0] release_id_o;
  logic [3:0] occupancy_o;
  int tests = 0, fails = 0;
  bit m_act[8];
  int m_id[8], m_cnt[8], m_seq[8];
  int seq_ctr, m_ptr, m_lslot;
  bit m_lock, m_valid, m_ready;
  int m_g, m_free, m_occ;

  simmem_wresp_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .waddr_valid_i(waddr_valid_i), .waddr_ready_o(waddr_ready_o),
    .waddr_id_i(waddr_id_i), .delay_i(delay_i), .release_valid_o(release_valid_o),
    .release_ready_i(release_ready_i), .release_id_o(release_id_o), .occupancy_o(occupancy_o)
  );
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 0; m_id[i] = 0; m_cnt[i] = 0; m_seq[i] = 0;
    end
    seq_ctr = 0; m_ptr = 0; m_lock = 0; m_lslot = 0;
  endtask

  function automatic bit eligible(int i);
    if (!m_act[i] || m_cnt[i] != 0) return 0;
    for (int k = 0; k < 8; k++)
      if (m_act[k] && m_id[k] == m_id[i] && m_seq[k] < m_seq[i]) return 0;
    return 1;
  endfunction

  task automatic model_eval();
    m_ready = 0; m_free = -1; m_occ = 0; m_valid = 0; m_g = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_act[i]) m_occ++;
      else if (m_free < 0) begin m_free = i; m_ready = 1; end
    end
    if (m_lock) begin
      m_valid = 1; m_g = m_lslot;
    end else
      for (int k = 0; k < 8; k++)
        if (!m_valid && eligible((m_ptr + k) % 8)) begin m_valid = 1; m_g = (m_ptr + k) % 8; end
  endtask

  task automatic model_update(input bit v, input int id, input int d, input bit r);
    for (int i = 0; i < 8; i++) if (m_act[i] && m_cnt[i] > 0) m_cnt[i]--;
    if (m_valid && r) begin
      m_act[m_g] = 0; m_ptr = (m_g + 1) % 8; m_lock = 0;
    end else if (m_valid) begin
      m_lock = 1; m_lslot = m_g;
    end
    if (v && m_ready) begin
      m_act[m_free] = 1; m_id[m_free] = id; m_cnt[m_free] = d; m_seq[m_free] = seq_ctr++;
    end
  endtask

  task automatic check_outputs();
    model_eval();
    check("waddr_ready", waddr_ready_o, m_ready);
    check("release_valid", release_valid_o, m_valid);
    check("release_id", release_id_o, m_valid ? m_id[m_g] : 0);
    check("occupancy", occupancy_o, m_occ);
  endtask

  task automatic cyc(input bit v, input int id, input int d, input bit r);
    waddr_valid_i = v; waddr_id_i = 4'(id); delay_i = 6'(d); release_ready_i = r;
    #1;
    check_outputs();
    @(posedge clk_i);
    model_update(v, id, d, r);
    @(negedge clk_i);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    check_outputs();
    rst_i = 1'b0;
    cyc(1, 3, 5, 1);
    repeat (8) cyc(0, 0, 0, 1);
    cyc(1, 2, 10, 1);
    cyc(1, 2, 1, 1);
    repeat (14) cyc(0, 0, 0, 1);
    cyc(1, 0, 3, 1);
    cyc(1, 1, 2, 1);
    cyc(1, 2, 1, 1);
    repeat (6) cyc(0, 0, 0, 1);
    cyc(1, 7, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 3, 0);
    cyc(1, 4, 2, 0);
    repeat (4) cyc(0, 0, 0, 1);
    cyc(1, 5, 1, 0);
    cyc(1, 6, 2, 0);
    repeat (6) cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, i, 20, 0);
    cyc(1, 9, 1, 0);
    repeat (22) cyc(0, 0, 0, 0);
    cyc(1, 9, 1, 1);
    repeat (3) cyc(1, 10, 1, 0);
    repeat (14) cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, i, 8, 0);
    repeat (2) cyc(0, 0, 0, 0);
    rst_i = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (12) cyc(0, 0, 0, 1);
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 3),
          ($urandom_range(0, 15) == 0) ? 63 : $urandom_range(0, 12), $urandom_range(0, 9) < 7);
    repeat (80) cyc(0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
